// File: rtl/wb_pix_fetch_pkg.sv
// Shared types for the frame-buffer pixel fetcher.
package wb_pix_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} fetch_state_t;

    typedef struct packed {
        logic              sof;
        logic [WORD_W-1:0] data;
    } pix_word_t;

endpackage

// File: rtl/wb_pix_fetch_if.sv
// Wishbone classic bus bundle; clock and synchronous active-high reset ride along.
interface wshb_if (
    input logic clk,
    input logic rst
);

    logic                           cyc;
    logic                           stb;
    logic                           we;
    logic [3:0]                     sel;
    logic [wb_pix_pkg::WORD_W-1:0]  adr;
    logic [wb_pix_pkg::WORD_W-1:0]  dat_ms;
    logic [wb_pix_pkg::WORD_W-1:0]  dat_sm;
    logic                           ack;
    logic [2:0]                     cti;
    logic [1:0]                     bte;

    modport master (
        input  clk, rst, dat_sm, ack,
        output cyc, stb, we, sel, adr, dat_ms, cti, bte
    );

    modport slave (
        input  clk, rst, cyc, stb, we, sel, adr, dat_ms, cti, bte,
        output dat_sm, ack
    );

endinterface

// File: rtl/wb_pix_fetch_sync_fifo.sv
// Single-clock FIFO with a registered head word; push and pop may coincide at any fill level.
module sync_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign dout  = dout_q;

    always_comb begin
        // A pop on empty is dropped; a push on full only lands when a pop frees the slot.
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        dout_d   = dout_q;
        // Slot being written is the next head only when the FIFO is otherwise empty.
        if (do_push && (wr_ptr_q == rd_ptr_d)) begin
            dout_d = din;
        end else if (do_pop) begin
            dout_d = mem[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/wb_pix_fetch.sv
// Read-only Wishbone classic master streaming a frame buffer into a pixel FIFO.
module wb_pix_fetch
    import wb_pix_pkg::*;
#(
    parameter int unsigned HDISP      = 640,
    parameter int unsigned VDISP      = 480,
    parameter logic [31:0] BASE_ADR   = 32'h0,
    parameter int unsigned FIFO_DEPTH = 16
) (
    wshb_if.master      wb_m,
    input  logic        en,
    output logic [31:0] pix_data,
    output logic        pix_sof,
    output logic        pix_valid,
    input  logic        pix_ready
);

    localparam int unsigned NPIX  = HDISP * VDISP;
    localparam int unsigned IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    fetch_state_t     state_q, state_d;
    logic [IDX_W-1:0] pix_idx_q, pix_idx_d;
    logic [31:0]      adr_q, adr_d;

    logic             fifo_push, fifo_empty, fifo_full, pix_pop;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   count_next;
    pix_word_t        fifo_din, fifo_dout;

    assign pix_pop    = pix_ready && pix_valid;
    assign fifo_push  = (state_q == REQ) && wb_m.ack;
    assign fifo_din   = '{sof: (pix_idx_q == '0), data: wb_m.dat_sm};
    // Occupancy after the push that accompanies an ack.
    assign count_next = {1'b0, fifo_count} + (CNT_W + 1)'(1) - (CNT_W + 1)'(pix_pop);

    always_comb begin
        state_d   = state_q;
        pix_idx_d = pix_idx_q;
        adr_d     = adr_q;
        unique case (state_q)
            IDLE: begin
                if (en && !fifo_full) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (wb_m.ack) begin
                    state_d = (en && (count_next < (CNT_W + 1)'(FIFO_DEPTH))) ? REQ : IDLE;
                    if (pix_idx_q == IDX_W'(NPIX - 1)) begin
                        pix_idx_d = '0;
                        adr_d     = BASE_ADR;
                    end else begin
                        pix_idx_d = pix_idx_q + IDX_W'(1);
                        adr_d     = adr_q + 32'd4;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_m.clk) begin
        if (wb_m.rst) begin
            state_q   <= IDLE;
            pix_idx_q <= '0;
            adr_q     <= BASE_ADR;
        end else begin
            state_q   <= state_d;
            pix_idx_q <= pix_idx_d;
            adr_q     <= adr_d;
        end
    end

    assign wb_m.cyc    = (state_q == REQ);
    assign wb_m.stb    = (state_q == REQ);
    assign wb_m.we     = 1'b0;
    assign wb_m.sel    = 4'hF;
    assign wb_m.adr    = adr_q;
    assign wb_m.dat_ms = '0;
    assign wb_m.cti    = 3'b000;
    assign wb_m.bte    = 2'b00;

    sync_fifo #(
        .WIDTH ($bits(pix_word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (wb_m.clk),
        .rst   (wb_m.rst),
        .push  (fifo_push),
        .pop   (pix_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign pix_valid = !fifo_empty;
    assign pix_data  = fifo_dout.data;
    assign pix_sof   = fifo_dout.sof;

endmodule

// File: tb/tb_wb_pix_fetch.sv
// Scoreboard bench: the slave model queues expected pixels on each ack, a monitor checks pops.
module tb_wb_pix_fetch;
    import wb_pix_pkg::*;

    localparam int unsigned HDISP = 4;
    localparam int unsigned VDISP = 2;
    localparam int unsigned NPIX  = HDISP * VDISP;
    localparam logic [31:0] BASE  = 32'h100;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        rdy_main = 1'b0;
    logic        rdy_sync = 1'b0;
    logic        pix_ready;
    logic [31:0] pix_data;
    logic        pix_sof;
    logic        pix_valid;

    always #5 clk = ~clk;
    assign pix_ready = rdy_main | rdy_sync;

    wshb_if wb (.clk(clk), .rst(rst));

    wb_pix_fetch #(
        .HDISP      (HDISP),
        .VDISP      (VDISP),
        .BASE_ADR   (BASE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .wb_m      (wb),
        .en        (en),
        .pix_data  (pix_data),
        .pix_sof   (pix_sof),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready)
    );

    int          checks = 0;
    int          errors = 0;
    pix_word_t   exp_q[$];
    int          lat = 0;
    bit          sync_pop = 1'b0;
    bit          stray = 1'b0;
    int          ack_cnt = 0;
    int          pop_cnt = 0;
    int          model_idx = 0;
    bit          busy = 1'b0;
    int          wcnt = 0;
    logic [31:0] hold_adr = '0;
    logic [31:0] last_adr = '0;
    logic [31:0] exp_adr;
    pix_word_t   sl_w;
    pix_word_t   mon_w;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave model: acks after lat extra cycles, returns data = adr, predicts the stream.
    initial begin
        wb.ack    = 1'b0;
        wb.dat_sm = '0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                wb.ack    = 1'b0;
                busy      = 1'b0;
                rdy_sync  = 1'b0;
                model_idx = 0;
                exp_q.delete();
            end else if (wb.ack) begin
                wb.ack   = 1'b0;
                busy     = 1'b0;
                rdy_sync = 1'b0;
            end else if (wb.cyc && wb.stb) begin
                if (!busy) begin
                    busy     = 1'b1;
                    wcnt     = 0;
                    hold_adr = wb.adr;
                end else begin
                    check("adr_stable", wb.adr, hold_adr);
                    wcnt++;
                end
                if (wcnt >= lat) begin
                    exp_adr = BASE + 32'(model_idx * 4);
                    check("adr", wb.adr, exp_adr);
                    wb.ack     = 1'b1;
                    wb.dat_sm  = wb.adr;
                    sl_w.sof   = (model_idx == 0);
                    sl_w.data  = exp_adr;
                    exp_q.push_back(sl_w);
                    model_idx  = (model_idx + 1) % NPIX;
                    ack_cnt++;
                    last_adr   = wb.adr;
                    if (sync_pop) rdy_sync = 1'b1;
                end
            end else begin
                if (busy) check("stb_held", 64'(wb.stb), 64'd1);
                busy = 1'b0;
                if (stray) wb.ack = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && pix_valid && pix_ready) begin
                pop_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got 0x%0h, expected no word", pix_data);
                end else begin
                    mon_w = exp_q.pop_front();
                    check("pix_data", pix_data, mon_w.data);
                    check("pix_sof", 64'(pix_sof), 64'(mon_w.sof));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic wait_acks(input string name, input int target, input int budget);
        int i = 0;
        while (ack_cnt < target && i < budget) begin
            tick(1);
            i++;
        end
        check(name, ack_cnt, target);
    endtask

    task automatic wait_cyc(input string name, input logic level, input int budget);
        int i = 0;
        while (wb.cyc !== level && i < budget) begin
            tick(1);
            i++;
        end
        check(name, 64'(wb.cyc), 64'(level));
    endtask

    task automatic drain(input string name);
        int i = 0;
        rdy_main = 1'b1;
        while ((pix_valid || wb.cyc) && i < 30) begin
            tick(1);
            i++;
        end
        tick(1);
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        int base;
        int pbase;
        int k;
        int n;
        tick(2);
        check("rst_cyc", 64'(wb.cyc), 64'd0);
        check("rst_stb", 64'(wb.stb), 64'd0);
        check("rst_adr", wb.adr, BASE);
        check("rst_valid", 64'(pix_valid), 64'd0);
        check("rst_sof", 64'(pix_sof), 64'd0);
        check("rst_data", pix_data, 32'h0);
        check("tie_we", 64'(wb.we), 64'd0);
        check("tie_sel", wb.sel, 4'hF);
        check("tie_cti", wb.cti, 3'b000);
        check("tie_bte", wb.bte, 2'b00);

        // Streaming with a consumer that always accepts, across the frame wrap.
        rst = 1'b0; en = 1'b1; rdy_main = 1'b1; lat = 0;
        base = ack_cnt;
        wait_cyc("t1_start", 1'b1, 10);
        n = 0;
        while (ack_cnt < base + 9 && n < 40) begin
            check("t1_cyc_held", 64'(wb.cyc), 64'd1);
            tick(1);
            n++;
        end
        check("t1_acks", ack_cnt - base, 9);
        check("t1_wrap_adr", last_adr, BASE);
        en = 1'b0;
        wait_cyc("t1_idle", 1'b0, 10);
        drain("t1_drain");

        // Stalled consumer fills the FIFO; one pop admits exactly one read.
        do_reset();
        rdy_main = 1'b0; en = 1'b1;
        base = ack_cnt;
        tick(30);
        check("t2_acks_full", ack_cnt - base, 4);
        check("t2_cyc_full", 64'(wb.cyc), 64'd0);
        check("t2_valid", 64'(pix_valid), 64'd1);
        check("t2_head", pix_data, BASE);
        check("t2_head_sof", 64'(pix_sof), 64'd1);
        rdy_main = 1'b1;
        tick(1);
        rdy_main = 1'b0;
        tick(15);
        check("t2_acks_one", ack_cnt - base, 5);
        check("t2_adr_one", last_adr, 32'h110);
        check("t2_cyc_after", 64'(wb.cyc), 64'd0);
        en = 1'b0;
        drain("t2_drain");

        // Wait-stated slave.
        do_reset();
        lat = 3; rdy_main = 1'b1; en = 1'b1;
        base = ack_cnt;
        pbase = pop_cnt;
        wait_acks("t3_acks", base + 4, 60);
        en = 1'b0;
        wait_cyc("t3_idle", 1'b0, 20);
        drain("t3_drain");
        check("t3_push_per_ack", pop_cnt - pbase, ack_cnt - base);

        // en dropped in the first cycle of a transfer.
        do_reset();
        lat = 3; rdy_main = 1'b1; en = 1'b1;
        base = ack_cnt;
        wait_cyc("t4_start", 1'b1, 10);
        en = 1'b0;
        tick(12);
        check("t4_one_ack", ack_cnt - base, 1);
        check("t4_idle", 64'(wb.cyc), 64'd0);
        check("t4_adr0", last_adr, BASE);
        en = 1'b1;
        wait_cyc("t4_restart", 1'b1, 10);
        en = 1'b0;
        tick(12);
        check("t4_two_acks", ack_cnt - base, 2);
        check("t4_resume_adr", last_adr, 32'h104);
        drain("t4_drain");

        // Reset in the middle of a request.
        do_reset();
        lat = 0; rdy_main = 1'b1; en = 1'b1;
        base = ack_cnt;
        wait_acks("t5_acks", base + 5, 40);
        check("t5_in_req", 64'(wb.cyc), 64'd1);
        rst = 1'b1;
        tick(1);
        check("t5_rst_cyc", 64'(wb.cyc), 64'd0);
        check("t5_rst_stb", 64'(wb.stb), 64'd0);
        check("t5_rst_valid", 64'(pix_valid), 64'd0);
        rst = 1'b0;
        base = ack_cnt;
        wait_acks("t5_first", base + 1, 10);
        check("t5_first_adr", last_adr, BASE);
        en = 1'b0;
        drain("t5_drain");

        // Push with pop at the top of the FIFO.
        do_reset();
        lat = 0; rdy_main = 1'b0; en = 1'b1;
        base = ack_cnt;
        tick(20);
        check("t6_acks_full", ack_cnt - base, 4);
        rdy_main = 1'b1;
        tick(1);
        rdy_main = 1'b0;
        sync_pop = 1'b1;
        base = ack_cnt;
        wait_acks("t6_sync_acks", base + 4, 30);
        sync_pop = 1'b0;
        wait_cyc("t6_idle", 1'b0, 10);
        check("t6_extra_ack", ack_cnt - base, 5);
        check("t6_valid", 64'(pix_valid), 64'd1);
        en = 1'b0;
        pbase = pop_cnt;
        drain("t6_full_drain");
        check("t6_full_depth", pop_cnt - pbase, 4);

        // Push with pop on an empty FIFO.
        do_reset();
        lat = 0; rdy_main = 1'b1; en = 1'b1;
        for (k = 0; k < 3; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!wb.ack && n < 10);
            check("t6_empty_ack", 64'(wb.ack), 64'd1);
            check("t6_empty_before", 64'(pix_valid), 64'd0);
            @(posedge clk);
            #1;
            check("t6_empty_valid", 64'(pix_valid), 64'd1);
            check("t6_empty_data", pix_data, BASE + 32'(k * 4));
        end
        en = 1'b0;
        drain("t6_empty_drain");

        // Stray ack while idle.
        do_reset();
        stray = 1'b1;
        tick(1);
        stray = 1'b0;
        tick(4);
        check("t7_stray_valid", 64'(pix_valid), 64'd0);
        check("t7_stray_cyc", 64'(wb.cyc), 64'd0);
        check("t7_stray_adr", wb.adr, BASE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
